// File: rtl/timer_irq_gen.sv
// Memory-mapped programmable down-counter timer with one-shot and auto-reload modes.
// Raises irq toward cp0 when the count expires, gated by the CTRL interrupt mask.
module timer_irq_gen #(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_t           state;
    state_t           next_state;
    logic [3:0]       ctrl;
    logic [CNT_W-1:0] preset;
    logic [CNT_W-1:0] count;
    logic             irq_flag;

    logic             wr_ctrl;
    logic             wr_preset;
    logic             load_count;
    logic             dec_count;
    logic             zero_count;
    logic             set_flag;
    logic             clr_flag_hw;
    logic             clr_en;

    logic             en;
    logic [1:0]       mode;
    logic             im;

    assign en   = ctrl[0];
    assign mode = ctrl[2:1];
    assign im   = ctrl[3];

    assign wr_ctrl   = we && (addr[3:2] == 2'd0);
    assign wr_preset = we && (addr[3:2] == 2'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        load_count  = 1'b0;
        dec_count   = 1'b0;
        zero_count  = 1'b0;
        set_flag    = 1'b0;
        clr_flag_hw = 1'b0;
        clr_en      = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                load_count = 1'b1;
                next_state = CNT;
            end
            CNT: begin
                // A preset of 0 expires like a preset of 1; the count never wraps.
                if (!en) begin
                    next_state = IDLE;
                end else if (count > ONE) begin
                    dec_count = 1'b1;
                end else begin
                    zero_count = 1'b1;
                    set_flag   = 1'b1;
                    next_state = INT;
                end
            end
            INT: begin
                if (mode == 2'd1) begin
                    clr_flag_hw = 1'b1;
                    next_state  = LOAD;
                end else begin
                    clr_en     = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // A CPU write to CTRL overrides the hardware clearing of EN in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl <= 4'd0;
        end else if (wr_ctrl) begin
            ctrl <= wdata[3:0];
        end else if (clr_en) begin
            ctrl[0] <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            preset <= '0;
        end else if (wr_preset) begin
            preset <= wdata[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load_count) begin
            count <= preset;
        end else if (dec_count) begin
            count <= count - ONE;
        end else if (zero_count) begin
            count <= '0;
        end
    end

    // Setting the flag on expiry takes priority over a simultaneous software clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_flag <= 1'b0;
        end else if (set_flag) begin
            irq_flag <= 1'b1;
        end else if (clr_flag_hw || wr_ctrl || wr_preset) begin
            irq_flag <= 1'b0;
        end
    end

    assign irq = irq_flag & im;

    always_comb begin
        logic [31:0] preset_ext;
        logic [31:0] count_ext;
        preset_ext              = '0;
        count_ext               = '0;
        preset_ext[CNT_W-1:0]   = preset;
        count_ext[CNT_W-1:0]    = count;
        rdata                   = 32'd0;
        case (addr[3:2])
            2'd0:    rdata = {28'd0, ctrl};
            2'd1:    rdata = preset_ext;
            2'd2:    rdata = count_ext;
            default: rdata = 32'd0;
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^{addr[31:4], addr[1:0], wdata};

endmodule

// File: tb/tb_timer_irq_gen.sv
// Scoreboard bench for timer_irq_gen: directed register traffic with hand-computed
// expected reads and irq levels, checked by a separate monitor process.
module tb_timer_irq_gen;

   localparam logic [31:0] A_CTRL   = 32'h0000_0000;
   localparam logic [31:0] A_PRESET = 32'h0000_0004;
   localparam logic [31:0] A_COUNT  = 32'h0000_0008;
   localparam logic [31:0] A_RSV    = 32'h0000_000C;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        irq;
   } exp_t;

   exp_t sb_q[$];
   event sample_ev;
   int   checks   = 0;
   int   failures = 0;

   timer_irq_gen #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   // Free-running 100 MHz clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d);
      we    = 1'b1;
      addr  = a;
      wdata = d;
      @(posedge clk);
      #1;
      we    = 1'b0;
   endtask

   // Queues the expectation for the current cycle; the monitor samples one unit later.
   task automatic checkOutput(input string name, input logic [31:0] a,
                              input logic [31:0] exp_rdata, input logic exp_irq);
      exp_t e;
      addr    = a;
      e.name  = name;
      e.rdata = exp_rdata;
      e.irq   = exp_irq;
      sb_q.push_back(e);
      #1;
      -> sample_ev;
      #1;
   endtask

   // Monitor: compares sampled outputs against the queued expectation
   initial begin
      exp_t e;
      forever begin
         @(sample_ev);
         if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            checks++;
            if (rdata !== e.rdata || irq !== e.irq) begin
               failures++;
               $display("[TB] FAIL %s: got rdata=%h irq=%b, expected rdata=%h irq=%b",
                        e.name, rdata, irq, e.rdata, e.irq);
            end
         end
      end
   end

   // Watchdog against a hung simulation
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not complete in time");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main directed stimulus sequence
   initial begin
      int m1_cnt [11] = '{0, 3, 2, 1, 0, 0, 3, 2, 1, 0, 0};
      bit m1_irq [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
      int m1b_cnt[5]  = '{1, 0, 0, 6, 5};
      bit m1b_irq[5]  = '{0, 1, 0, 0, 0};

      reset = 1'b1;
      we    = 1'b0;
      addr  = 32'd0;
      wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      checkOutput("reset_ctrl", A_CTRL, 32'd0, 1'b0);

      // Reset asserted while counting
      step(1);
      applyStimulus(A_PRESET, 32'd10);
      applyStimulus(A_CTRL, 32'h9);
      step(4);
      checkOutput("precount", A_COUNT, 32'd8, 1'b0);
      reset = 1'b1;
      checkOutput("async_count", A_COUNT, 32'd0, 1'b0);
      checkOutput("async_ctrl", A_CTRL, 32'd0, 1'b0);
      checks++;
      if (irq !== 1'b0 || rdata !== 32'd0) begin
         failures++;
         $display("[TB] FAIL async_direct: irq=%b rdata=%h during reset", irq, rdata);
      end
      step(1);
      checkOutput("async_preset", A_PRESET, 32'd0, 1'b0);
      reset = 1'b0;
      step(2);
      checkOutput("post_reset_count", A_COUNT, 32'd0, 1'b0);
      checkOutput("post_reset_ctrl", A_CTRL, 32'd0, 1'b0);

      // Mode 0 one-shot
      step(1);
      applyStimulus(A_PRESET, 32'd5);
      applyStimulus(A_CTRL, 32'h9);
      checkOutput("m0_ctrl_written", A_CTRL, 32'h9, 1'b0);
      step(6);
      checkOutput("m0_e6_count", A_COUNT, 32'd1, 1'b0);
      step(1);
      checkOutput("m0_e7_count", A_COUNT, 32'd0, 1'b1);
      checkOutput("m0_e7_ctrl", A_CTRL, 32'h9, 1'b1);
      step(1);
      checkOutput("m0_en_cleared", A_CTRL, 32'h8, 1'b1);
      step(3);
      checkOutput("m0_irq_held", A_COUNT, 32'd0, 1'b1);
      applyStimulus(A_CTRL, 32'h8);
      checkOutput("m0_irq_cleared", A_CTRL, 32'h8, 1'b0);

      // Mode 1 auto-reload, then PRESET rewritten mid-count
      step(1);
      applyStimulus(A_PRESET, 32'd3);
      applyStimulus(A_CTRL, 32'hB);
      for (int i = 0; i < 11; i++) begin
         step(1);
         checkOutput($sformatf("m1_e%0d", i + 1), A_COUNT, 32'(m1_cnt[i]), m1_irq[i]);
      end
      step(1);
      checkOutput("m1_e12", A_COUNT, 32'd3, 1'b0);
      applyStimulus(A_PRESET, 32'd6);
      checkOutput("m1_e13_unaffected", A_COUNT, 32'd2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(1);
         checkOutput($sformatf("m1_e%0d", i + 14), A_COUNT, 32'(m1b_cnt[i]), m1b_irq[i]);
      end

      // EN cleared mid-count freezes COUNT
      applyStimulus(A_CTRL, 32'h0);
      checkOutput("stop_count", A_COUNT, 32'd4, 1'b0);
      step(1);
      checkOutput("frozen_1", A_COUNT, 32'd4, 1'b0);
      step(5);
      checkOutput("frozen_2", A_COUNT, 32'd4, 1'b0);
      checkOutput("frozen_ctrl", A_CTRL, 32'd0, 1'b0);

      // Masked interrupt
      step(1);
      applyStimulus(A_PRESET, 32'd2);
      applyStimulus(A_CTRL, 32'h1);
      step(2);
      checkOutput("im0_e2", A_COUNT, 32'd2, 1'b0);
      step(2);
      checkOutput("im0_int", A_COUNT, 32'd0, 1'b0);
      step(1);
      checkOutput("im0_idle", A_CTRL, 32'd0, 1'b0);
      applyStimulus(A_CTRL, 32'h8);
      checkOutput("im0_unmask", A_CTRL, 32'h8, 1'b0);

      // Flag set wins over PRESET write; CTRL write wins over EN clear
      step(1);
      applyStimulus(A_PRESET, 32'd2);
      applyStimulus(A_CTRL, 32'h9);
      step(3);
      checkOutput("sw_e3", A_COUNT, 32'd1, 1'b0);
      applyStimulus(A_PRESET, 32'd7);
      checkOutput("set_wins", A_COUNT, 32'd0, 1'b1);
      applyStimulus(A_CTRL, 32'h9);
      checkOutput("cpu_ctrl_wins", A_CTRL, 32'h9, 1'b0);
      step(2);
      checkOutput("rerun_load", A_COUNT, 32'd7, 1'b0);
      applyStimulus(A_CTRL, 32'h0);
      step(1);
      checkOutput("rerun_stop", A_COUNT, 32'd6, 1'b0);

      // Register map boundaries
      applyStimulus(A_COUNT, 32'h0000_FFFF);
      checkOutput("count_ro", A_COUNT, 32'd6, 1'b0);
      applyStimulus(A_RSV, 32'h0000_1234);
      checkOutput("rsv_zero", A_RSV, 32'd0, 1'b0);
      checkOutput("preset_alias", 32'h0000_1004, 32'd7, 1'b0);
      applyStimulus(A_CTRL, 32'hFFFF_FFF8);
      checkOutput("ctrl_upper_zero", A_CTRL, 32'h8, 1'b0);

      // PRESET of zero expires like one
      applyStimulus(A_PRESET, 32'd0);
      applyStimulus(A_CTRL, 32'h9);
      step(2);
      checkOutput("p0_cnt", A_COUNT, 32'd0, 1'b0);
      step(1);
      checkOutput("p0_int", A_COUNT, 32'd0, 1'b1);
      step(1);
      checkOutput("p0_idle", A_CTRL, 32'h8, 1'b1);

      step(2);
      if (checks < 12) begin
         failures++;
         $display("[TB] FAIL too few checks executed: %0d", checks);
      end
      if (failures != 0) begin
         $display("[TB] FAIL %0d of %0d checks failed", failures, checks);
      end else begin
         $display("[TB] PASS all %0d checks", checks);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
